// File: rtl/lcd_timing_gen.sv
// Raster timing generator for a parallel RGB LCD: walks the h/v counters, issues pixel
// requests upstream and drives DE/HSYNC/VSYNC/RGB after a fixed pipeline delay.
module lcd_timing_gen #(
    parameter int H_ACTIVE = 480,
    parameter int H_FP     = 8,
    parameter int H_SYNC   = 4,
    parameter int H_BP     = 43,
    parameter int V_ACTIVE = 272,
    parameter int V_FP     = 8,
    parameter int V_SYNC   = 4,
    parameter int V_BP     = 12,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int PIPE_DLY = 2,
    parameter int RGB_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    output logic             pix_req,
    output logic [9:0]       pix_x,
    output logic [8:0]       pix_y,
    output logic             frame_start,
    output logic             line_start,
    input  logic [RGB_W-1:0] rgb_in,
    output logic             lcd_de,
    output logic             lcd_hsync,
    output logic             lcd_vsync,
    output logic [RGB_W-1:0] lcd_rgb
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [HW-1:0]    h_q, h_d;
    logic [VW-1:0]    v_q, v_d;
    logic             pix_req_q, pix_req_d;
    logic [9:0]       pix_x_q, pix_x_d;
    logic [8:0]       pix_y_q, pix_y_d;
    logic             frame_start_q, frame_start_d;
    logic             line_start_q, line_start_d;
    logic             hs0_q, hs0_d;
    logic             vs0_q, vs0_d;
    logic [2:0]       dly_q [PIPE_DLY];
    logic             de_pre_s;
    logic [RGB_W-1:0] rgb_q, rgb_d;

    // Raster counters: v advances only on the h wrap
    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            if (v_q == V_LAST) begin
                v_d = '0;
            end else begin
                v_d = v_q + VW'(1);
            end
        end else begin
            h_d = h_q + HW'(1);
        end
    end

    // Stage 0 decode of the current raster position
    always_comb begin
        pix_req_d     = (h_q < H_ACT) && (v_q < V_ACT);
        pix_x_d       = pix_req_d ? 10'(h_q) : 10'd0;
        pix_y_d       = pix_req_d ? 9'(v_q) : 9'd0;
        hs0_d         = (h_q >= H_SS) && (h_q < H_SE);
        vs0_d         = (v_q >= V_SS) && (v_q < V_SE);
        frame_start_d = (h_q == '0) && (v_q == '0);
        line_start_d  = (h_q == '0) && (v_q < V_ACT);
    end

    // Counters and stage 0 registers
    always_ff @(posedge clk) begin
        if (rst) begin
            h_q           <= '0;
            v_q           <= '0;
            pix_req_q     <= 1'b0;
            pix_x_q       <= 10'd0;
            pix_y_q       <= 9'd0;
            hs0_q         <= 1'b0;
            vs0_q         <= 1'b0;
            frame_start_q <= 1'b0;
            line_start_q  <= 1'b0;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            pix_req_q     <= pix_req_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            hs0_q         <= hs0_d;
            vs0_q         <= vs0_d;
            frame_start_q <= frame_start_d;
            line_start_q  <= line_start_d;
        end
    end

    // {de, hs, vs} delay line matching the upstream source latency
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PIPE_DLY; i++) begin
                dly_q[i] <= 3'b000;
            end
        end else begin
            dly_q[0] <= {pix_req_q, hs0_q, vs0_q};
            for (int i = 1; i < PIPE_DLY; i++) begin
                dly_q[i] <= dly_q[i-1];
            end
        end
    end

    // DE one stage before the pins selects whether rgb_in is captured this edge
    generate
        if (PIPE_DLY == 1) begin : g_pd1
            assign de_pre_s = pix_req_q;
        end else begin : g_pdn
            assign de_pre_s = dly_q[PIPE_DLY-2][2];
        end
    endgenerate

    // Blanking pixels are forced to zero
    always_comb begin
        rgb_d = de_pre_s ? rgb_in : {RGB_W{1'b0}};
    end

    // Panel RGB register
    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_q <= {RGB_W{1'b0}};
        end else begin
            rgb_q <= rgb_d;
        end
    end

    assign pix_req     = pix_req_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign frame_start = frame_start_q;
    assign line_start  = line_start_q;
    assign lcd_de      = dly_q[PIPE_DLY-1][2];
    assign lcd_hsync   = dly_q[PIPE_DLY-1][1] ? HS_POL : ~HS_POL;
    assign lcd_vsync   = dly_q[PIPE_DLY-1][0] ? VS_POL : ~VS_POL;
    assign lcd_rgb     = rgb_q;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Scoreboard bench for lcd_timing_gen: two small raster configurations checked cycle by
// cycle against a position-arithmetic reference model, with random resets and RGB junk.
module tb_lcd_timing_gen;

    localparam int A_HA = 4, A_HF = 1, A_HS = 2, A_HB = 1;
    localparam int A_VA = 3, A_VF = 1, A_VS = 1, A_VB = 1;
    localparam int A_PD = 3;
    localparam bit A_HP = 1'b0, A_VP = 1'b0;
    localparam int A_HT = A_HA + A_HF + A_HS + A_HB;
    localparam int A_FT = A_HT * (A_VA + A_VF + A_VS + A_VB);

    localparam int B_HA = 6, B_HF = 2, B_HS = 3, B_HB = 2;
    localparam int B_VA = 4, B_VF = 1, B_VS = 2, B_VB = 2;
    localparam int B_PD = 1;
    localparam bit B_HP = 1'b1, B_VP = 1'b1;
    localparam int B_FT = (B_HA + B_HF + B_HS + B_HB) * (B_VA + B_VF + B_VS + B_VB);

    localparam int N_CYC = 3000;

    typedef struct packed {
        logic        req;
        logic [9:0]  x;
        logic [8:0]  y;
        logic        fs;
        logic        ls;
        logic        de;
        logic        hs;
        logic        vs;
        logic [15:0] rgb;
    } obs_t;

    typedef struct {
        obs_t e;
        int   n;
    } item_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] rgb_a, rgb_b;
    logic        a_req, a_fs, a_ls, a_de, a_hs, a_vs;
    logic [9:0]  a_x;
    logic [8:0]  a_y;
    logic [15:0] a_rgb;
    logic        b_req, b_fs, b_ls, b_de, b_hs, b_vs;
    logic [9:0]  b_x;
    logic [8:0]  b_y;
    logic [15:0] b_rgb;

    item_t q_a[$];
    item_t q_b[$];
    int    tests = 0;
    int    fails = 0;

    int    last_fs [2];
    int    ls_cnt  [2];
    int    req_cnt [2];
    int    run     [2];
    bit    fs_ok   [2];

    logic       hr_a [4];
    logic [9:0] hx_a [4];
    logic [8:0] hy_a [4];
    logic       hr_b [4];
    logic [9:0] hx_b [4];
    logic [8:0] hy_b [4];

    always #5 clk = ~clk;

    lcd_timing_gen #(
        .H_ACTIVE(A_HA), .H_FP(A_HF), .H_SYNC(A_HS), .H_BP(A_HB),
        .V_ACTIVE(A_VA), .V_FP(A_VF), .V_SYNC(A_VS), .V_BP(A_VB),
        .HS_POL(A_HP), .VS_POL(A_VP), .PIPE_DLY(A_PD), .RGB_W(16)
    ) u_dut_a (
        .clk(clk), .rst(rst), .pix_req(a_req), .pix_x(a_x), .pix_y(a_y),
        .frame_start(a_fs), .line_start(a_ls), .rgb_in(rgb_a),
        .lcd_de(a_de), .lcd_hsync(a_hs), .lcd_vsync(a_vs), .lcd_rgb(a_rgb)
    );

    lcd_timing_gen #(
        .H_ACTIVE(B_HA), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
        .V_ACTIVE(B_VA), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB),
        .HS_POL(B_HP), .VS_POL(B_VP), .PIPE_DLY(B_PD), .RGB_W(16)
    ) u_dut_b (
        .clk(clk), .rst(rst), .pix_req(b_req), .pix_x(b_x), .pix_y(b_y),
        .frame_start(b_fs), .line_start(b_ls), .rgb_in(rgb_b),
        .lcd_de(b_de), .lcd_hsync(b_hs), .lcd_vsync(b_vs), .lcd_rgb(b_rgb)
    );

    function automatic logic [15:0] rgb_of(int x, int y);
        logic [15:0] r;
        r = 16'(((y & 255) << 8) | (x & 255));
        return r;
    endfunction

    // Expected outputs after the n-th edge since reset release (n=0: in reset).
    function automatic obs_t model(int n, int ha, int hf, int hs, int hb,
                                   int va, int vf, int vs, int vb, int pd,
                                   bit hp, bit vp);
        obs_t e;
        int   ht, ft, p, h, v;
        bit   act;
        ht = ha + hf + hs + hb;
        ft = ht * (va + vf + vs + vb);
        e = '0;
        e.hs = ~hp;
        e.vs = ~vp;
        if (n >= 1) begin
            p = (n - 1) % ft;
            h = p % ht;
            v = p / ht;
            act = (h < ha) && (v < va);
            e.req = act;
            if (act) begin
                e.x = 10'(h);
                e.y = 9'(v);
            end
            e.fs = (p == 0);
            e.ls = (h == 0) && (v < va);
        end
        if (n >= pd + 1) begin
            p = (n - 1 - pd) % ft;
            h = p % ht;
            v = p / ht;
            act = (h < ha) && (v < va);
            e.de  = act;
            e.hs  = (h >= ha + hf && h < ha + hf + hs) ? hp : ~hp;
            e.vs  = (v >= va + vf && v < va + vf + vs) ? vp : ~vp;
            e.rgb = act ? rgb_of(h, v) : 16'd0;
        end
        return e;
    endfunction

    task automatic push(int n);
        item_t ia, ib;
        ia.e = model(n, A_HA, A_HF, A_HS, A_HB, A_VA, A_VF, A_VS, A_VB, A_PD, A_HP, A_VP);
        ia.n = n;
        ib.e = model(n, B_HA, B_HF, B_HS, B_HB, B_VA, B_VF, B_VS, B_VB, B_PD, B_HP, B_VP);
        ib.n = n;
        q_a.push_back(ia);
        q_b.push_back(ib);
    endtask

    task automatic check(int k, string nm, item_t it, obs_t o, int ha, int va, int ft);
        tests++;
        if (o !== it.e) begin
            fails++;
            $display("FAIL out_%s n=%0d got req=%b x=%0d y=%0d fs=%b ls=%b de=%b hs=%b vs=%b rgb=%h want req=%b x=%0d y=%0d fs=%b ls=%b de=%b hs=%b vs=%b rgb=%h",
                     nm, it.n, o.req, o.x, o.y, o.fs, o.ls, o.de, o.hs, o.vs, o.rgb,
                     it.e.req, it.e.x, it.e.y, it.e.fs, it.e.ls, it.e.de, it.e.hs, it.e.vs, it.e.rgb);
        end
        if (it.n == 0) begin
            fs_ok[k] = 1'b0;
            run[k]   = 0;
        end else begin
            if (o.fs === 1'b1) begin
                if (fs_ok[k]) begin
                    tests++;
                    if ((it.n - last_fs[k]) != ft || ls_cnt[k] != va || req_cnt[k] != ha * va) begin
                        fails++;
                        $display("FAIL frame_%s n=%0d got period=%0d lines=%0d reqs=%0d want period=%0d lines=%0d reqs=%0d",
                                 nm, it.n, it.n - last_fs[k], ls_cnt[k], req_cnt[k], ft, va, ha * va);
                    end
                end
                fs_ok[k]   = 1'b1;
                last_fs[k] = it.n;
                ls_cnt[k]  = 0;
                req_cnt[k] = 0;
            end
            if (o.ls === 1'b1) ls_cnt[k]++;
            if (o.req === 1'b1) req_cnt[k]++;
            if (o.de === 1'b1) begin
                run[k]++;
            end else begin
                if (run[k] > 0) begin
                    tests++;
                    if (run[k] != ha) begin
                        fails++;
                        $display("FAIL de_run_%s n=%0d got %0d want %0d", nm, it.n, run[k], ha);
                    end
                end
                run[k] = 0;
            end
        end
    endtask

    // Monitor: one scoreboard entry per clock edge for each instance
    always @(negedge clk) begin
        item_t it;
        obs_t  o;
        if (q_a.size() > 0) begin
            it = q_a.pop_front();
            o  = {a_req, a_x, a_y, a_fs, a_ls, a_de, a_hs, a_vs, a_rgb};
            check(0, "A", it, o, A_HA, A_VA, A_FT);
        end
        if (q_b.size() > 0) begin
            it = q_b.pop_front();
            o  = {b_req, b_x, b_y, b_fs, b_ls, b_de, b_hs, b_vs, b_rgb};
            check(1, "B", it, o, B_HA, B_VA, B_FT);
        end
    end

    // Driver and pixel source
    initial begin
        int n;
        int rst_left;
        bit rst_next;
        bit mid_done;
        n        = 0;
        rst_left = 0;
        mid_done = 1'b0;
        for (int i = 0; i < 2; i++) begin
            last_fs[i] = 0;
            ls_cnt[i]  = 0;
            req_cnt[i] = 0;
            run[i]     = 0;
            fs_ok[i]   = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            hr_a[i] = 1'b0; hx_a[i] = 10'd0; hy_a[i] = 9'd0;
            hr_b[i] = 1'b0; hx_b[i] = 10'd0; hy_b[i] = 9'd0;
        end
        rst   = 1'b1;
        rgb_a = 16'd0;
        rgb_b = 16'd0;
        push(0);
        for (int c = 0; c < N_CYC; c++) begin
            @(posedge clk);
            #1;
            for (int i = 3; i > 0; i--) begin
                hr_a[i] = hr_a[i-1]; hx_a[i] = hx_a[i-1]; hy_a[i] = hy_a[i-1];
                hr_b[i] = hr_b[i-1]; hx_b[i] = hx_b[i-1]; hy_b[i] = hy_b[i-1];
            end
            hr_a[0] = a_req; hx_a[0] = a_x; hy_a[0] = a_y;
            hr_b[0] = b_req; hx_b[0] = b_x; hy_b[0] = b_y;

            if (c < 3) begin
                rst_next = 1'b1;
            end else if (rst_left > 0) begin
                rst_next = 1'b1;
                rst_left--;
            end else if (!mid_done && c > 400 && n >= 1 && ((n - 1) % A_FT) == (A_HT + 2)) begin
                rst_next = 1'b1;
                rst_left = 2;
                mid_done = 1'b1;
            end else if (c > 600 && $urandom_range(0, 199) == 0) begin
                rst_next = 1'b1;
                rst_left = $urandom_range(0, 2);
            end else begin
                rst_next = 1'b0;
            end
            rst = rst_next;
            n   = rst_next ? 0 : n + 1;

            rgb_a = hr_a[A_PD-1] ? rgb_of(hx_a[A_PD-1], hy_a[A_PD-1]) : 16'($urandom);
            rgb_b = hr_b[B_PD-1] ? rgb_of(hx_b[B_PD-1], hy_b[B_PD-1]) : 16'($urandom);
            push(n);
        end
        @(posedge clk);
        @(negedge clk);
        #1;
        tests++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            fails++;
            $display("FAIL drain got %0d/%0d pending want 0/0", q_a.size(), q_b.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
